// File: rtl/bcd_seg_scan.sv
// -----------------------------------------------------------------------------
// bcd_seg_scan
//
// Time-multiplexed 7-segment display driver for unpacked BCD digits.
// One value can wait in a pending buffer. It moves into the display
// register only at the last cycle of a frame, so a frame never shows a
// mix of old and new digits. Each digit slot begins with one cycle in
// which every digit enable is off. This stops the previous digit's
// segments from ghosting onto the next digit.
//
// Parameters:
//   DIGITS     number of scanned digits (>= 1)
//   PRESCALE   clock cycles per digit slot (>= 2)
//   ACTIVE_LOW 1: seg/dp/an are inverted at the pins; 0: active-high
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   bcd_valid   bcd_in/dp_in offered
//   bcd_ready   pending buffer empty (transfer on bcd_valid & bcd_ready)
//   bcd_in      4*DIGITS unpacked BCD, digit i at [4i+3:4i], digit 0 rightmost
//   dp_in       decimal point per digit
//   seg         segments {g,f,e,d,c,b,a}
//   dp          decimal point of the active digit
//   an          one-hot digit enable
//   frame_tick  one-cycle pulse at the start of each frame
//
// Optional feature: define SEG_LZB_EN for leading-zero blanking. When it is
// enabled, a digit i > 0 shows no segments if it and every higher digit are
// zero. Digit 0 is never blanked.
// -----------------------------------------------------------------------------
module bcd_seg_scan #(
  parameter int DIGITS     = 4,
  parameter int PRESCALE   = 1000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bcd_valid,
  output logic                  bcd_ready,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [CW-1:0]         cnt_reg;
  logic [IW-1:0]         idx_reg;
  logic [4*DIGITS-1:0]   disp_digits_reg;
  logic [DIGITS-1:0]     disp_dp_reg;
  logic [4*DIGITS-1:0]   pend_digits_reg;
  logic [DIGITS-1:0]     pend_dp_reg;
  logic                  pend_full_reg;

  logic                  slot_end;
  logic                  frame_end;

  assign slot_end  = (cnt_reg == CNT_LAST);
  assign frame_end = slot_end && (idx_reg == IDX_LAST);

  // ---------------------------------------------------------------------------
  // Scan counters, pending buffer and frame-boundary commit
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg         <= '0;
      idx_reg         <= '0;
      disp_digits_reg <= '0;
      disp_dp_reg     <= '0;
      pend_digits_reg <= '0;
      pend_dp_reg     <= '0;
      pend_full_reg   <= 1'b0;
    end else begin
      if (slot_end) begin
        cnt_reg <= '0;
        idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + IW'(1);
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end

      // A commit and an accept can never occur together. An accept needs
      // pend_full low, and a commit needs it high. So a value accepted in
      // the commit cycle is held until the next frame boundary.
      if (frame_end && pend_full_reg) begin
        disp_digits_reg <= pend_digits_reg;
        disp_dp_reg     <= pend_dp_reg;
        pend_full_reg   <= 1'b0;
      end else if (bcd_valid && !pend_full_reg) begin
        pend_digits_reg <= bcd_in;
        pend_dp_reg     <= dp_in;
        pend_full_reg   <= 1'b1;
      end
    end
  end

  assign bcd_ready = !pend_full_reg;

  // ---------------------------------------------------------------------------
  // Per-digit views of the display register
  // ---------------------------------------------------------------------------
  logic [3:0]        digit_w [DIGITS];
  logic [DIGITS-1:0] blank_w;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign digit_w[gi] = disp_digits_reg[4*gi +: 4];
`ifdef SEG_LZB_EN
      if (gi == 0) begin : g_no_blank
        assign blank_w[gi] = 1'b0;
      end else begin : g_lzb
        // Blank when this digit and everything above it are zero.
        assign blank_w[gi] = (disp_digits_reg[4*DIGITS-1:4*gi] == '0);
      end
`else
      assign blank_w[gi] = 1'b0;
`endif
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Output decode (Moore: depends only on registers)
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;  // non-BCD nibble shows a minus sign
    endcase
    return s;
  endfunction

  logic [3:0]        cur_digit;
  logic [6:0]        seg_raw;
  logic              dp_raw;
  logic [DIGITS-1:0] an_raw;

  assign cur_digit = digit_w[idx_reg];
  assign seg_raw   = blank_w[idx_reg] ? 7'h00 : seg_decode(cur_digit);
  assign dp_raw    = disp_dp_reg[idx_reg];
  // First cycle of every slot is the ghosting guard: no digit enabled.
  assign an_raw    = (cnt_reg == '0) ? '0 : (DIGITS'(1) << idx_reg);

  assign seg        = ACTIVE_LOW ? ~seg_raw : seg_raw;
  assign dp         = ACTIVE_LOW ? ~dp_raw  : dp_raw;
  assign an         = ACTIVE_LOW ? ~an_raw  : an_raw;
  assign frame_tick = (cnt_reg == '0) && (idx_reg == '0);

endmodule

// File: tb/tb_bcd_seg_scan.sv
// -----------------------------------------------------------------------------
// tb_bcd_seg_scan
//
// Self-checking bench for bcd_seg_scan with DIGITS=4, PRESCALE=4 and
// ACTIVE_LOW=0. A reference model tracks the time since reset, the
// display value and the pending value. It derives the expected seg, dp,
// an, frame_tick and bcd_ready each cycle from plain arithmetic on that
// time. The directed phases follow the test plan, and randomized
// traffic follows them.
// -----------------------------------------------------------------------------
module tb_bcd_seg_scan;

  localparam int DIGITS   = 4;
  localparam int PRESCALE = 4;
  localparam int FRAME    = DIGITS * PRESCALE;

  localparam logic [6:0] SEG_TAB [0:15] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40
  };

  logic                clk = 1'b0;
  logic                rst;
  logic                bcd_valid;
  logic                bcd_ready;
  logic [4*DIGITS-1:0] bcd_in;
  logic [DIGITS-1:0]   dp_in;
  logic [6:0]          seg;
  logic                dp;
  logic [DIGITS-1:0]   an;
  logic                frame_tick;

  bcd_seg_scan #(
    .DIGITS     (DIGITS),
    .PRESCALE   (PRESCALE),
    .ACTIVE_LOW (1'b0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bcd_valid  (bcd_valid),
    .bcd_ready  (bcd_ready),
    .bcd_in     (bcd_in),
    .dp_in      (dp_in),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state. It always describes the DUT state that
  // follows the most recent rising edge.
  int          m_t;          // cycles since reset
  logic [15:0] m_disp;
  logic [3:0]  m_disp_dp;
  logic [15:0] m_pend;
  logic [3:0]  m_pend_dp;
  bit          m_full;
  bit          last_accept;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (model t=%0d, time %0t)", tag, got, exp, m_t, $time);
    end
  endtask

  // One clock cycle. Compare outputs at the falling edge, drive the inputs,
  // then advance the model to the state after the coming rising edge.
  task automatic step(input bit v, input logic [15:0] d, input logic [3:0] p, input bit r);
    int         c;
    int         i;
    logic [3:0] nib;
    logic [6:0] es;
    logic [3:0] ea;
    @(negedge clk);
    c   = m_t % PRESCALE;
    i   = (m_t / PRESCALE) % DIGITS;
    nib = 4'(m_disp >> (4 * i));
    es  = SEG_TAB[nib];
`ifdef SEG_LZB_EN
    if (i > 0 && (m_disp >> (4 * i)) == 16'h0) es = 7'h00;
`endif
    ea = (c == 0) ? 4'b0000 : 4'(1 << i);
    check("seg",        32'(seg),        32'(es));
    check("dp",         32'(dp),         32'(m_disp_dp[i]));
    check("an",         32'(an),         32'(ea));
    check("frame_tick", 32'(frame_tick), 32'(m_t % FRAME == 0));
    check("bcd_ready",  32'(bcd_ready),  32'(!m_full));
    $display("t=%0d slot=%0d cnt=%0d seg=%02h dp=%0b an=%04b ready=%0b | valid=%0b in=%04h dp_in=%04b rst=%0b",
             m_t, i, c, seg, dp, an, bcd_ready, v, d, p, r);

    rst       = r;
    bcd_valid = v;
    bcd_in    = d;
    dp_in     = p;

    last_accept = 1'b0;
    if (r) begin
      m_t       = 0;
      m_disp    = 16'h0;
      m_disp_dp = 4'h0;
      m_full    = 1'b0;
    end else begin
      if (m_t % FRAME == FRAME - 1 && m_full) begin
        m_disp    = m_pend;
        m_disp_dp = m_pend_dp;
        m_full    = 1'b0;
      end else if (v && !m_full) begin
        m_pend      = d;
        m_pend_dp   = p;
        m_full      = 1'b1;
        last_accept = 1'b1;
      end
      m_t++;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 16'($urandom), 4'($urandom), 1'b0);
  endtask

  task automatic send(input logic [15:0] d, input logic [3:0] p);
    int n = 0;
    do begin
      step(1'b1, d, p, 1'b0);
      n++;
    end while (!last_accept && n < 64);
    check("send_accepted", 32'(last_accept), 32'd1);
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] v;
    for (int k = 0; k < 4; k++) begin
      case ($urandom_range(0, 3))
        0:       v[4*k +: 4] = 4'd0;
        1, 2:    v[4*k +: 4] = 4'($urandom_range(0, 9));
        default: v[4*k +: 4] = 4'($urandom_range(0, 15));
      endcase
    end
    return v;
  endfunction

  initial begin
    int n;
    rst       = 1'b1;
    bcd_valid = 1'b0;
    bcd_in    = '0;
    dp_in     = '0;
    m_t       = 0;
    m_disp    = 16'h0;
    m_disp_dp = 4'h0;
    m_pend    = 16'h0;
    m_pend_dp = 4'h0;
    m_full    = 1'b0;
    last_accept = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state, then the first idle frames
    idle(20);

    // 0255 with dp on digit 1
    send(16'h0255, 4'b0010);
    idle(40);

    // Back-to-back: the second value waits for the frame boundary
    send(16'h1111, 4'b0000);
    send(16'h2222, 4'b0000);
    idle(40);

    // Non-BCD nibble decodes to a minus sign
    send(16'h00A9, 4'b0001);
    idle(36);

    // Transfer in the commit cycle with pend empty
    n = 0;
    while (((m_t % FRAME) != FRAME - 1 || m_full) && n < 64) begin
      step(1'b0, 16'h0, 4'h0, 1'b0);
      n++;
    end
    check("wait_commit_cycle", 32'(n < 64), 32'd1);
    step(1'b1, 16'h4321, 4'b1000, 1'b0);
    check("commit_cycle_accept", 32'(last_accept), 32'd1);
    idle(40);

    // Reset mid-frame at idx=2, cnt=2 while a value is pending
    send(16'h9876, 4'b0100);
    n = 0;
    while (((m_t % FRAME) != 0 || m_full) && n < 64) begin
      step(1'b0, 16'h0, 4'h0, 1'b0);
      n++;
    end
    check("wait_frame_start", 32'(n < 64), 32'd1);
    send(16'h5555, 4'b1111);
    n = 0;
    while ((m_t % FRAME) != 10 && n < 64) begin
      step(1'b0, 16'h0, 4'h0, 1'b0);
      n++;
    end
    check("wait_mid_frame", 32'(n < 64), 32'd1);
    check("pend_full_before_rst", 32'(bcd_ready), 32'd0);
    step(1'b0, 16'h0, 4'h0, 1'b1);
    idle(20);

    // Randomized traffic with occasional resets
    for (int k = 0; k < 800; k++) begin
      step($urandom_range(0, 2) == 0, rand_bcd(), 4'($urandom),
           $urandom_range(0, 199) == 0);
    end
    idle(FRAME * 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
